// File: rtl/cl_axi_mon_pkg.sv
// Shared definitions for the PCIS->DDR AXI4 transaction monitor.
//   ERR_* : bit positions inside the sticky error vector
//   ERR_W : width of the error vector
//   axi_len_t : AXI4 AxLEN field (burst length minus one)
//   burst_beats() : converts an AxLEN value into a beat count
package cl_axi_mon_pkg;

  localparam int ERR_AW_OVF   = 0;
  localparam int ERR_WLEN_MIS = 1;
  localparam int ERR_W_ORPHAN = 2;
  localparam int ERR_B_ORPHAN = 3;
  localparam int ERR_R_ORPHAN = 4;
  localparam int ERR_TIMEOUT  = 5;
  localparam int ERR_W        = 6;

  typedef logic [7:0]       axi_len_t;
  typedef logic [ERR_W-1:0] err_vec_t;

  // Beat count is one wider than AxLEN so that len=255 maps to 256.
  function automatic logic [8:0] burst_beats(input axi_len_t len);
    return {1'b0, len} + 9'd1;
  endfunction

endpackage

// File: rtl/cl_axi_mon_if.sv
// Handshake-level view of one AXI4 port (AW, W, B, AR, R control signals only).
// Handshake rule on every channel: a transfer ("fire") happens on a rising clock
// edge where both valid and ready are high; the source holds valid and its
// payload stable until that edge, and ready may toggle freely.
// Modports:
//   master : drives valids/payload of AW, W, AR and the B/R readies
//   slave  : drives the AW/W/AR readies and B/R valids/payload
//   mon    : observes everything, drives nothing
interface cl_axi_mon_if;
  import cl_axi_mon_pkg::*;

  logic     awvalid;
  logic     awready;
  axi_len_t awlen;
  logic     wvalid;
  logic     wready;
  logic     wlast;
  logic     bvalid;
  logic     bready;
  logic     arvalid;
  logic     arready;
  axi_len_t arlen;
  logic     rvalid;
  logic     rready;
  logic     rlast;

  modport master (
    output awvalid, awlen, wvalid, wlast, bready, arvalid, arlen, rready,
    input  awready, wready, bvalid, arready, rvalid, rlast
  );

  modport slave (
    input  awvalid, awlen, wvalid, wlast, bready, arvalid, arlen, rready,
    output awready, wready, bvalid, arready, rvalid, rlast
  );

  modport mon (
    input awvalid, awready, awlen, wvalid, wready, wlast, bvalid, bready,
          arvalid, arready, arlen, rvalid, rready, rlast
  );
endinterface

// File: rtl/cl_axi_mon_lenq.sv
// Synchronous FIFO of AW burst lengths awaiting their WLAST.
//   clk, rst (async, active high), clr (sync clear)
//   push/push_len : enqueue; ignored when full unless pop is accepted the same cycle
//   pop           : dequeue head; ignored when empty
//   full, empty, head : status and oldest entry
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
module cl_axi_mon_lenq
  import cl_axi_mon_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     clr,
  input  logic     push,
  input  axi_len_t push_len,
  input  logic     pop,
  output logic     full,
  output logic     empty,
  output axi_len_t head
);
  localparam int             PW       = $clog2(DEPTH);
  localparam logic [PW:0]    FULL_CNT = (PW+1)'(DEPTH);

  axi_len_t      mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == FULL_CNT);
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  // A pop frees the slot before the push lands, so full+pop+push is legal.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read while counted as occupied.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wr_ptr_q] <= push_len;
  end

endmodule

// File: rtl/cl_axi_txn_mon.sv
// Passive AXI4 transaction checker for the PCIS->DDR path, feeding the debug ILA.
// Ports:
//   aclk, areset (async, active high), clr (sync clear of flags/counters/queue)
//   bus      : cl_axi_mon_if.mon, observed only
//   wr_outs  : AW accepted minus B accepted (saturating)
//   rd_outs  : AR accepted minus RLAST accepted (saturating)
//   err      : sticky {timeout, r_orphan, b_orphan, w_orphan, wlen_mis, aw_ovf}
//   trig     : one-cycle pulse whenever any err bit rises
// Optional feature macro CL_AXI_MON_PERF_EN adds wr_beats/rd_beats (wrapping
// W/R beat counters) and max_wr_outs (high-water mark of wr_outs).
module cl_axi_txn_mon
  import cl_axi_mon_pkg::*;
#(
  parameter int LENQ_DEPTH  = 8,
  parameter int OUTS_W      = 6,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              clr,
  cl_axi_mon_if.mon         bus,
  output logic [OUTS_W-1:0] wr_outs,
  output logic [OUTS_W-1:0] rd_outs,
  output err_vec_t          err,
  output logic              trig
`ifdef CL_AXI_MON_PERF_EN
  ,
  output logic [31:0]       wr_beats,
  output logic [31:0]       rd_beats,
  output logic [OUTS_W-1:0] max_wr_outs
`endif
);
  localparam int                WD_W     = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0]   WD_LIMIT = WD_W'(TIMEOUT_CYC);
  localparam logic [OUTS_W-1:0] OUTS_MAX = '1;

  logic aw_fire, w_fire, b_fire, ar_fire, r_fire, wlast_fire, any_fire, pending;
  logic q_push, q_pop, q_full, q_empty, bypass;
  axi_len_t q_head, exp_len;
  logic unused_arlen;

  logic [OUTS_W-1:0] wr_outs_q, wr_outs_d, rd_outs_q, rd_outs_d, wr_inc, rd_inc;
  logic [8:0]        wbeat_q, wbeat_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  err_vec_t          err_q, err_d, err_new;
  logic              trig_q, trig_d;

  assign aw_fire    = bus.awvalid && bus.awready;
  assign w_fire     = bus.wvalid  && bus.wready;
  assign b_fire     = bus.bvalid  && bus.bready;
  assign ar_fire    = bus.arvalid && bus.arready;
  assign r_fire     = bus.rvalid  && bus.rready;
  assign wlast_fire = w_fire && bus.wlast;
  assign any_fire   = aw_fire || w_fire || b_fire || ar_fire || r_fire;
  assign pending    = (wr_outs_q != '0) || (rd_outs_q != '0) || !q_empty;
  assign unused_arlen = ^bus.arlen;

  // A WLAST arriving with the queue empty closes the burst whose AW fires in
  // the same cycle; that length is consumed directly and never enqueued.
  assign bypass = wlast_fire && q_empty && aw_fire;
  assign q_pop  = wlast_fire && !q_empty;
  assign q_push = aw_fire && !bypass;

  cl_axi_mon_lenq #(.DEPTH(LENQ_DEPTH)) u_lenq (
    .clk      (aclk),
    .rst      (areset),
    .clr      (clr),
    .push     (q_push),
    .push_len (bus.awlen),
    .pop      (q_pop),
    .full     (q_full),
    .empty    (q_empty),
    .head     (q_head)
  );

  always_comb begin
    err_new = '0;
    wbeat_d = wbeat_q;
    exp_len = q_head;
    wr_inc  = wr_outs_q;
    rd_inc  = rd_outs_q;
    wdog_d  = wdog_q;

    if (w_fire) begin
      if (bus.wlast) begin
        wbeat_d = '0;
        if (!q_empty || aw_fire) begin
          exp_len = q_empty ? bus.awlen : q_head;
          if ((wbeat_q + 9'd1) != burst_beats(exp_len)) err_new[ERR_WLEN_MIS] = 1'b1;
        end else begin
          err_new[ERR_W_ORPHAN] = 1'b1;
        end
      end else begin
        wbeat_d = wbeat_q + 9'd1;
      end
    end

    if (aw_fire && q_full && !q_pop) err_new[ERR_AW_OVF] = 1'b1;

    // B/RLAST are judged against the count after any same-cycle increment.
    if (aw_fire && (wr_outs_q != OUTS_MAX)) wr_inc = wr_outs_q + 1'b1;
    wr_outs_d = wr_inc;
    if (b_fire) begin
      if (wr_inc == '0) err_new[ERR_B_ORPHAN] = 1'b1;
      else              wr_outs_d = wr_inc - 1'b1;
    end

    if (ar_fire && (rd_outs_q != OUTS_MAX)) rd_inc = rd_outs_q + 1'b1;
    rd_outs_d = rd_inc;
    if (r_fire && bus.rlast) begin
      if (rd_inc == '0) err_new[ERR_R_ORPHAN] = 1'b1;
      else              rd_outs_d = rd_inc - 1'b1;
    end

    // Watchdog holds at the limit so the flag is raised exactly once.
    if (any_fire || !pending)     wdog_d = '0;
    else if (wdog_q != WD_LIMIT)  wdog_d = wdog_q + 1'b1;
    if ((TIMEOUT_CYC != 0) && (wdog_d == WD_LIMIT)) err_new[ERR_TIMEOUT] = 1'b1;

    err_d  = err_q | err_new;
    trig_d = |(err_new & ~err_q);

    if (clr) begin
      wbeat_d   = '0;
      wr_outs_d = '0;
      rd_outs_d = '0;
      wdog_d    = '0;
      err_d     = '0;
      trig_d    = 1'b0;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_outs_q <= '0;
      rd_outs_q <= '0;
      wbeat_q   <= '0;
      wdog_q    <= '0;
      err_q     <= '0;
      trig_q    <= 1'b0;
    end else begin
      wr_outs_q <= wr_outs_d;
      rd_outs_q <= rd_outs_d;
      wbeat_q   <= wbeat_d;
      wdog_q    <= wdog_d;
      err_q     <= err_d;
      trig_q    <= trig_d;
    end
  end

  assign wr_outs = wr_outs_q;
  assign rd_outs = rd_outs_q;
  assign err     = err_q;
  assign trig    = trig_q;

`ifdef CL_AXI_MON_PERF_EN
  logic [31:0]       wr_beats_q, wr_beats_d, rd_beats_q, rd_beats_d;
  logic [OUTS_W-1:0] max_wr_q, max_wr_d;

  always_comb begin
    wr_beats_d = wr_beats_q + (w_fire ? 32'd1 : 32'd0);
    rd_beats_d = rd_beats_q + (r_fire ? 32'd1 : 32'd0);
    max_wr_d   = (wr_outs_d > max_wr_q) ? wr_outs_d : max_wr_q;
    if (clr) begin
      wr_beats_d = '0;
      rd_beats_d = '0;
      max_wr_d   = '0;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_beats_q <= '0;
      rd_beats_q <= '0;
      max_wr_q   <= '0;
    end else begin
      wr_beats_q <= wr_beats_d;
      rd_beats_q <= rd_beats_d;
      max_wr_q   <= max_wr_d;
    end
  end

  assign wr_beats    = wr_beats_q;
  assign rd_beats    = rd_beats_q;
  assign max_wr_outs = max_wr_q;
`endif

endmodule
